// File: rtl/pc_msg_pkg.sv
// Shared definitions for the PC-to-FPGA message deframer: state encoding,
// STOP pattern, default message geometry and a constant clog2 helper.
package pc_msg_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPATCH = 2'd2;

    // A STOP message is every bit of the assembled message equal to this value
    localparam logic STOP_FILL = 1'b0;

    // Default host message geometry (one word matches XB_SIZE)
    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_MSG_WORDS = 3;

    // Ceiling log2; clog2(1) = 0. Only used on constants.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count events, holding at the maximum value instead of wrapping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_msg_deframer.sv
// Assembles fixed-length host messages from the FWFT word stream, routes each
// to one consumer channel over valid/ready, echoes accepted words, flags STOP
// messages and drops stalled partial messages after an idle timeout.
module pc_msg_deframer
    import pc_msg_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MSG_WORDS = DEF_MSG_WORDS,
    parameter int N_CH      = 3,
    parameter int CH_LSB    = 0,
    parameter int CH_BITS   = 2,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16,
    parameter int DELAY     = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           pc_msg_valid,
    input  logic [WORD_SIZE-1:0]           pc_msg,
    output logic                           pc_msg_ack,
    output logic [N_CH-1:0]                msg_valid,
    input  logic [N_CH-1:0]                msg_ready,
    output logic [MSG_WORDS*WORD_SIZE-1:0] msg_data,
    output logic                           msg_is_stop,
    output logic                           echo_valid,
    output logic [WORD_SIZE-1:0]           echo_data,
    output logic                           err_timeout,
    output logic                           err_bad_ch,
    output logic [CNT_W-1:0]               n_msg,
    output logic [CNT_W-1:0]               n_err,
    output logic                           busy
);

    localparam int MSG_BITS = MSG_WORDS * WORD_SIZE;
    localparam int IW       = (MSG_WORDS > 1) ? clog2(MSG_WORDS) : 1;
    localparam int TW       = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    localparam logic [IW-1:0]      LAST_IDX = IW'(MSG_WORDS - 1);
    localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CH_BITS:0]   CH_LIMIT = (CH_BITS + 1)'(N_CH);

    logic [1:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic [TW-1:0]         r_idle_cnt;
    logic [MSG_BITS-1:0]   r_msg_data;
    logic [N_CH-1:0]       r_msg_valid;
    logic                  r_is_stop;
    logic                  r_echo_valid;
    logic [WORD_SIZE-1:0]  r_echo_data;
    logic                  r_err_timeout;
    logic                  r_err_bad_ch;

    logic                  w_ack;
    logic                  w_last;
    logic [MSG_BITS-1:0]   w_next_data;
    logic [CH_BITS-1:0]    w_ch;
    logic                  w_ch_ok;
    logic [N_CH-1:0]       w_onehot;
    logic                  w_stop;
    logic                  w_bad;
    logic                  w_timeout;
    logic                  w_hs;
    logic                  w_err_inc;
    logic                  w_unused_delay;

    // DELAY exists for compatibility with the behavioural model; registered
    // assignments in this implementation carry no delay.
    assign w_unused_delay = (DELAY != 0);

    // FWFT read strobe: take the word whenever one is offered, except while a
    // finished message is still waiting for its consumer.
    assign w_ack  = pc_msg_valid && (r_state != DISPATCH);
    assign w_last = w_ack && (r_idx == LAST_IDX);

    // Message image including the word accepted this cycle, so the channel
    // and STOP decisions see the complete message on the last-word cycle.
    generate
        for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_word
            assign w_next_data[gi*WORD_SIZE +: WORD_SIZE] =
                (w_ack && (r_idx == IW'(gi))) ? pc_msg
                                              : r_msg_data[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign w_ch    = w_next_data[CH_LSB +: CH_BITS];
    assign w_ch_ok = ({1'b0, w_ch} < CH_LIMIT);
    assign w_stop  = (w_next_data == {MSG_BITS{STOP_FILL}});

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_ch == CH_BITS'(gi));
        end
    endgenerate

    assign w_bad     = w_last && !w_ch_ok;
    assign w_timeout = (r_state == COLLECT) && !w_ack && (r_idle_cnt == TO_LAST);
    // Only the addressed channel's ready matters: r_msg_valid is one-hot.
    assign w_hs      = |(r_msg_valid & msg_ready);
    assign w_err_inc = w_bad || w_timeout;

    // Message assembly, channel evaluation, dispatch hold and idle timeout
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_idle_cnt  <= '0;
            r_msg_data  <= '0;
            r_msg_valid <= '0;
            r_is_stop   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_ack) begin
                        r_msg_data <= w_next_data;
                        r_idle_cnt <= '0;
                        if (w_last) begin
                            r_idx <= '0;
                            if (w_ch_ok) begin
                                r_state     <= DISPATCH;
                                r_msg_valid <= w_onehot;
                                r_is_stop   <= w_stop;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= COLLECT;
                        end
                    end else if (w_timeout) begin
                        r_idx      <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= IDLE;
                    end else if (r_state == COLLECT) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                DISPATCH: begin
                    if (w_hs) begin
                        r_state     <= IDLE;
                        r_msg_valid <= '0;
                        r_is_stop   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_idx       <= '0;
                    r_idle_cnt  <= '0;
                    r_msg_valid <= '0;
                    r_is_stop   <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle echo of each accepted word and error event pulses
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_echo_valid  <= 1'b0;
            r_echo_data   <= '0;
            r_err_timeout <= 1'b0;
            r_err_bad_ch  <= 1'b0;
        end else begin
            r_echo_valid  <= w_ack;
            if (w_ack) begin
                r_echo_data <= pc_msg;
            end
            r_err_timeout <= w_timeout;
            r_err_bad_ch  <= w_bad;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_n_msg (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_inc   (w_hs),
        .o_count (n_msg)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_n_err (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_inc   (w_err_inc),
        .o_count (n_err)
    );

    assign pc_msg_ack  = w_ack;
    assign msg_valid   = r_msg_valid;
    assign msg_data    = r_msg_data;
    assign msg_is_stop = r_is_stop;
    assign echo_valid  = r_echo_valid;
    assign echo_data   = r_echo_data;
    assign err_timeout = r_err_timeout;
    assign err_bad_ch  = r_err_bad_ch;
    assign busy        = (r_state != IDLE);

endmodule
